// File: rtl/msg_block_fetch.sv
// msg_block_fetch: pairs 256-bit ROM reads into 512-bit SHA-256 blocks behind a valid/ready handshake (optional MSG_FETCH_BSWAP_EN byte-reverses each 32-bit word)
module msg_block_fetch #(
  parameter int MEM_ADDR_WIDTH = 7,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic [MEM_ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]      num_blocks,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
  input  logic [255:0]              mem_dout,
  output logic                      blk_valid,
  input  logic                      blk_ready,
  output logic [511:0]              blk_data,
  output logic                      blk_last,
  output logic [CNT_WIDTH-1:0]      blk_idx,
  output logic                      busy,
  output logic                      done
);
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, CAP_LO, OUT, FIN} state_t;
  state_t                    r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_ptr;
  logic [CNT_WIDTH-1:0]      r_rem;
  logic                      r_mem_ren;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_raddr;
  logic                      r_blk_valid;
  logic [511:0]              r_blk_data;
  logic                      r_blk_last;
  logic [CNT_WIDTH-1:0]      r_blk_idx;
  logic                      r_busy;
  logic                      r_done;
  logic [255:0]              w_word;
  logic                      w_hs;
  assign w_hs      = r_blk_valid & blk_ready;
  assign mem_ren   = r_mem_ren;
  assign mem_raddr = r_mem_raddr;
  assign blk_valid = r_blk_valid;
  assign blk_data  = r_blk_data;
  assign blk_last  = r_blk_last;
  assign blk_idx   = r_blk_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  // ROM word as it is stored into the block (optionally byte-reversed per 32-bit word)
  always_comb begin
    w_word = mem_dout;
`ifdef MSG_FETCH_BSWAP_EN
    for (int i = 0; i < 8; i++)
      w_word[32*i +: 32] = {mem_dout[32*i +: 8], mem_dout[32*i+8 +: 8], mem_dout[32*i+16 +: 8], mem_dout[32*i+24 +: 8]};
`else
`endif
  end
  // Fetch sequencer; r_ptr always holds the next address to issue and mem_raddr is zeroed whenever no read is issued
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_rem       <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_raddr <= '0;
      r_blk_valid <= 1'b0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_blk_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_state     <= IDLE;
      r_mem_ren   <= 1'b0;
      r_mem_raddr <= '0;
      r_blk_valid <= 1'b0;
      r_blk_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      if (w_hs && !r_blk_last) begin
        r_rem     <= r_rem - 1'b1;
        r_blk_idx <= r_blk_idx + 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_busy    <= 1'b1;
          r_blk_idx <= '0;
          r_rem     <= num_blocks;
          if (num_blocks == '0) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_state     <= RD_HI;
            r_mem_ren   <= 1'b1;
            r_mem_raddr <= start_addr;
            r_ptr       <= start_addr + 1'b1;
          end
        end
        RD_HI: begin
          r_mem_raddr <= r_ptr;
          r_ptr       <= r_ptr + 1'b1;
          r_state     <= RD_LO;
        end
        RD_LO: begin
          r_blk_data[511:256] <= w_word;
          r_mem_ren           <= 1'b0;
          r_mem_raddr         <= '0;
          r_state             <= CAP_LO;
        end
        CAP_LO: begin
          r_blk_data[255:0] <= w_word;
          r_blk_valid       <= 1'b1;
          r_blk_last        <= (r_rem == CNT_WIDTH'(1));
          r_state           <= OUT;
        end
        OUT: if (w_hs) begin
          r_blk_valid <= 1'b0;
          r_blk_last  <= 1'b0;
          if (r_blk_last) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_rem       <= r_rem - 1'b1;
            r_blk_idx   <= r_blk_idx + 1'b1;
            r_mem_ren   <= 1'b1;
            r_mem_raddr <= r_ptr;
            r_ptr       <= r_ptr + 1'b1;
            r_state     <= RD_HI;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
